// File: rtl/block_assembler.sv
// block_assembler: expands (run, value) symbols into 64 zig-zag coefficients per 8x8 block,
// one registered coefficient per cycle, with optional DC delta prediction.
module block_assembler #(
    parameter bit DELTA_DECODE = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] value_in,
    input  logic [5:0]  run_in,
    input  logic        dc_in,
    input  logic        valid_in,
    input  logic        restart_in,
    output logic        ready_out,
    output logic [11:0] coef_out,
    output logic [5:0]  index_out,
    output logic        valid_out,
    output logic        last_out,
    output logic        err_out
);
    typedef enum logic [1:0] {ACCEPT, RUN, FILL} state_t;
    state_t state, state_d;
    logic [5:0] pos, pos_d, cnt, cnt_d, emit_idx;
    logic [11:0] lat, lat_d, pred, pred_d, emit_val, dc_val;
    logic emit, err;

    assign ready_out = (state == ACCEPT) && rst_in;

    // A run symbol emits its first zero on the accepting edge, so cnt holds the zeros still owed.
    always_comb begin
        state_d = state;
        pos_d = pos;
        cnt_d = cnt;
        lat_d = lat;
        pred_d = restart_in ? '0 : pred;
        dc_val = DELTA_DECODE ? value_in + pred_d : value_in;
        emit = 1'b0;
        emit_idx = pos;
        emit_val = '0;
        err = 1'b0;
        case (state)
            ACCEPT: if (valid_in) begin
                if (dc_in) begin
                    emit = 1'b1;
                    emit_idx = '0;
                    emit_val = dc_val;
                    pred_d = dc_val;
                    err = pos != '0;
                end else if (pos == '0) begin
                    err = 1'b1;
                end else if (run_in == '0) begin
                    emit = 1'b1;
                    emit_val = value_in;
                    if (value_in == '0) state_d = FILL;
                end else begin
                    emit = 1'b1;
                    err = pos == 6'd63;
                    lat_d = value_in;
                    cnt_d = run_in - 6'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                emit = 1'b1;
                emit_val = cnt == '0 ? lat : '0;
                err = cnt != '0 && pos == 6'd63;
                cnt_d = cnt == '0 ? '0 : cnt - 6'd1;
                state_d = cnt == '0 ? ACCEPT : RUN;
            end
            FILL: emit = 1'b1;
            default: state_d = ACCEPT;
        endcase
        // A zero of a pending run landing on idx63 means its value would overflow the block.
        if (emit) pos_d = emit_idx + 6'd1;
        if (emit && emit_idx == 6'd63) state_d = ACCEPT;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ACCEPT;
            pos <= '0;
            cnt <= '0;
            lat <= '0;
            pred <= '0;
            coef_out <= '0;
            index_out <= '0;
            valid_out <= 1'b0;
            last_out <= 1'b0;
            err_out <= 1'b0;
        end else begin
            state <= state_d;
            pos <= pos_d;
            cnt <= cnt_d;
            lat <= lat_d;
            pred <= pred_d;
            coef_out <= emit_val;
            index_out <= emit ? emit_idx : '0;
            valid_out <= emit;
            last_out <= emit && emit_idx == 6'd63;
            err_out <= err;
        end
    end
endmodule
